mine_count_engine: RTL and testbench
====================================

Name: mine_count_engine

Overview:
Consumes the 25-bit mine map produced by the mine-placement RNG and turns it into per-cell adjacency counts for the 5x5 board. On a start pulse it snapshots the map and scans cells 0..24 in order. For each cell it emits index, neighbour-mine count and mine flag over a valid/ready stream. The reveal/display logic downstream is the stream consumer.

Parameters:
ROWS, 5, board rows
COLS, 5, board columns; cell index = row*COLS + col; bit i of map = cell i
CNT_W, 4, width of neighbour count (max 8)
IDX_W, 5, width of cell index, ceil(log2(ROWS*COLS))

Ports:
in_clka  input  1  clock; all state updates on falling edge
in_reset  input  1  asynchronous, active-high reset
in_start  input  1  begin scan; sampled only in IDLE
in_mines  input  ROWS*COLS  mine map, 1 = mine; sampled on accepted in_start only
in_ready  input  1  consumer can accept current beat
out_valid  output  1  beat valid
out_index  output  IDX_W  cell index of current beat
out_count  output  CNT_W  number of mines among the up-to-8 neighbours of out_index
out_is_mine  output  1  snapshot bit at out_index
out_busy  output  1  high in SCAN and DONE
out_done  output  1  one-cycle pulse after the last beat is accepted
out_total  output  IDX_W  popcount of snapshot; valid while out_done=1, held until next start

Behaviour:
- Reset (async, any state): state=IDLE, snapshot=0, index=0, out_total=0. All outputs 0.
- States: IDLE, SCAN, DONE.
- IDLE: if in_start=1 at a clock edge, then snapshot<=in_mines, index<=0, go to SCAN.
- SCAN: out_valid=1. out_index=index. out_count and out_is_mine are combinational from snapshot and index.
  - At an edge with in_ready=1: if index=ROWS*COLS-1, go to DONE and latch out_total. Otherwise index<=index+1.
  - At an edge with in_ready=0: hold. Beat fields stay stable while valid and not accepted.
- DONE: out_done=1 and out_valid=0 for exactly one cycle, then go to IDLE.
- Latency with in_ready tied high:
  - Start sampled at edge 0.
  - Beat k is presented after edge k, for k=0..24.
  - out_done is high after edge 25.
  - Block is in IDLE after edge 26.
  - 27 cycles total from start to IDLE.
- in_start while busy is ignored. The snapshot is not updated during a scan, even if in_mines changes.
- Neighbour rules: the 8-neighbourhood is clipped at board edges, with no wrap-around. Corner cells have 3 neighbours, edge cells 5, interior cells 8. The cell itself is never counted.
- A mine cell still reports its true neighbour count, with out_is_mine=1.
- Width rules: count is unsigned, max 8, fits CNT_W. out_total max 25, fits IDX_W.
- Reset asserted mid-scan aborts immediately with no out_done pulse. out_total keeps its reset value of 0.
- in_start sampled in the same cycle as DONE is ignored. It is accepted only from IDLE.

Decomposition:
- Shared package mine_pkg:
  - constants ROWS, COLS, CELLS=ROWS*COLS, IDX_W, CNT_W
  - FSM state encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2
  - The RNG uses the same package so both ends agree on the bit-to-cell mapping.
- Sub-module neighbor_counter (combinational):
  - inputs: map[CELLS-1:0], idx
  - outputs: count[CNT_W-1:0], is_mine
  - does row/col decode plus the 8 clipped neighbour taps
- Engine: FSM, index counter, snapshot register, popcount for out_total.

Test Plan:
- Map=0, ready=1, start pulse -> 25 beats at indices 0..24, each count=0 and is_mine=0; out_done after edge 25; out_total=0.
- Map=all ones -> counts: corners (0,4,20,24)=3; edges (e.g. 1,5,9,23)=5; interior (6,12,18)=8; all is_mine=1; out_total=25.
- Single mine at 12 -> indices 6,7,8,11,13,16,17,18 count=1; idx12 is_mine=1 count=0; others 0; out_total=1.
- Mine at 4 only (corner) -> idx 3,8,9 count=1. idx 5 count=0, proving no wrap between col 4 and the next row's col 0.
- Backpressure: ready low for 3 cycles at beat 7 -> index/count held stable, no skipped or duplicate beats; done is delayed by exactly 3 cycles.
- Reset asserted at beat 10 -> outputs 0 immediately, no done pulse. A new start with a different map -> scan restarts at index 0 using the new snapshot. Also, in_start pulsed mid-scan -> ignored, no restart.

Source files
------------

// File: rtl/mine_pkg.sv
// ============================================================================
// mine_pkg : board geometry, FSM encoding and popcount shared by RNG and engine
// Rev 1.0
// ============================================================================
`default_nettype none

package mine_pkg;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = 4;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] popcount(input logic [CELLS-1:0] m);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) begin
      n = n + IDX_W'(m[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mine_count_engine_if.sv
// ============================================================================
// mine_count_engine_if : start/map input and per-cell result stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface mine_count_engine_if;
  import mine_pkg::*;

  logic             in_start;
  logic [CELLS-1:0] in_mines;
  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] out_count;
  logic             out_is_mine;
  logic             out_busy;
  logic             out_done;
  logic [IDX_W-1:0] out_total;

  modport slave (
    input  in_start, in_mines, in_ready,
    output out_valid, out_index, out_count, out_is_mine,
    output out_busy, out_done, out_total
  );

  modport master (
    output in_start, in_mines, in_ready,
    input  out_valid, out_index, out_count, out_is_mine,
    input  out_busy, out_done, out_total
  );

endinterface

`default_nettype wire

// File: rtl/neighbor_counter.sv
// ============================================================================
// neighbor_counter : clipped 8-neighbourhood mine count for one cell
// Rev 1.0
// ============================================================================
`default_nettype none

module neighbor_counter
  import mine_pkg::*;
(
  input  logic [CELLS-1:0] map,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] count,
  output logic             is_mine
);

  always_comb begin
    int row;
    int col;
    count   = '0;
    is_mine = map[idx];
    row     = int'(idx) / COLS;
    col     = int'(idx) % COLS;
    // Taps outside the board are dropped, so row ends never wrap into the next row.
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) &&
            (row + dr >= 0) && (row + dr < ROWS) &&
            (col + dc >= 0) && (col + dc < COLS)) begin
          count = count + CNT_W'(map[IDX_W'((row + dr) * COLS + (col + dc))]);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mine_count_engine.sv
// ============================================================================
// mine_count_engine : snapshots a mine map and streams per-cell counts 0..24
// Rev 1.0
// ============================================================================
`default_nettype none

module mine_count_engine
  import mine_pkg::*;
(
  input  logic                 in_clka,
  input  logic                 in_reset,
  mine_count_engine_if.slave   bus
);

  state_t           state_q, state_d;
  logic [CELLS-1:0] snap_q,  snap_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] total_q, total_d;

  logic [CNT_W-1:0] nb_count;
  logic             nb_mine;

  neighbor_counter u_nbr (
    .map     (snap_q),
    .idx     (idx_q),
    .count   (nb_count),
    .is_mine (nb_mine)
  );

  always_ff @(negedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          snap_d  = bus.in_mines;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.in_ready) begin
          if (idx_q == IDX_W'(CELLS - 1)) begin
            total_d = popcount(snap_q);
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat fields are zeroed outside SCAN so idle outputs read as all-zero.
  logic scan_active;
  assign scan_active     = (state_q == SCAN);

  assign bus.out_valid   = scan_active;
  assign bus.out_index   = scan_active ? idx_q    : '0;
  assign bus.out_count   = scan_active ? nb_count : '0;
  assign bus.out_is_mine = scan_active ? nb_mine  : 1'b0;
  assign bus.out_busy    = (state_q == SCAN) || (state_q == DONE);
  assign bus.out_done    = (state_q == DONE);
  assign bus.out_total   = total_q;

endmodule

`default_nettype wire

// File: tb/tb_mine_count_engine.sv
// ============================================================================
// tb_mine_count_engine : directed scans of mine_count_engine with fixed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mine_count_engine;
  import mine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mine_count_engine_if bus ();

  mine_count_engine dut (
    .in_clka  (clk),
    .in_reset (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt [CELLS];

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // DUT acts on the falling edge; drive and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input string s);
    for (int i = 0; i < CELLS; i++) begin
      exp_cnt[i] = int'(s[i]) - 48;
    end
  endtask

  task automatic scan(input string name, input logic [CELLS-1:0] map, input string exp_s,
                      input int stall_beat, input int stall_len, input int inject_beat,
                      input int exp_total);
    load_exp(exp_s);
    bus.in_mines = map;
    bus.in_ready = 1'b1;
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      if (k == inject_beat) begin
        bus.in_start = 1'b1;
        bus.in_mines = ~map;
      end
      if (k == inject_beat + 1) bus.in_start = 1'b0;
      chk({name, " valid"},   int'(bus.out_valid),   1);
      chk({name, " index"},   int'(bus.out_index),   k);
      chk({name, " count"},   int'(bus.out_count),   exp_cnt[k]);
      chk({name, " is_mine"}, int'(bus.out_is_mine), int'(map[k]));
      if (k == stall_beat) begin
        bus.in_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk({name, " stall valid"}, int'(bus.out_valid), 1);
          chk({name, " stall index"}, int'(bus.out_index), k);
          chk({name, " stall count"}, int'(bus.out_count), exp_cnt[k]);
        end
        bus.in_ready = 1'b1;
      end
      step();
    end
    chk({name, " done"},       int'(bus.out_done),  1);
    chk({name, " done valid"}, int'(bus.out_valid), 0);
    chk({name, " done busy"},  int'(bus.out_busy),  1);
    chk({name, " total"},      int'(bus.out_total), exp_total);
    // A start seen while in DONE must not launch a new scan.
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
    bus.in_mines = map;
    chk({name, " idle busy"},  int'(bus.out_busy),  0);
    chk({name, " idle done"},  int'(bus.out_done),  0);
    chk({name, " idle valid"}, int'(bus.out_valid), 0);
    chk({name, " held total"}, int'(bus.out_total), exp_total);
    step();
    chk({name, " still idle"}, int'(bus.out_busy),  0);
  endtask

  initial begin
    bus.in_start = 1'b0;
    bus.in_mines = '0;
    bus.in_ready = 1'b0;
    #1;
    chk("reset valid",   int'(bus.out_valid),   0);
    chk("reset index",   int'(bus.out_index),   0);
    chk("reset count",   int'(bus.out_count),   0);
    chk("reset is_mine", int'(bus.out_is_mine), 0);
    chk("reset busy",    int'(bus.out_busy),    0);
    chk("reset done",    int'(bus.out_done),    0);
    chk("reset total",   int'(bus.out_total),   0);
    step();
    rst = 1'b0;
    step();

    scan("empty",   25'h0000000, "0000000000000000000000000", -1, 0, -1, 0);
    scan("full",    25'h1FFFFFF, "3555358885588855888535553", -1, 0, -1, 25);
    scan("mid",     25'h0001000, "0000001110010100111000000", -1, 0, -1, 1);
    scan("corner",  25'h0000010, "0001000011000000000000000", -1, 0,  5, 1);
    scan("stall",   25'h1000001, "0100011000000000001100010",  7, 3, -1, 2);

    // Abort a scan with reset at beat 10.
    bus.in_mines = 25'h1FFFFFF;
    bus.in_ready = 1'b1;
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
    repeat (10) step();
    chk("abort pre index", int'(bus.out_index), 10);
    rst = 1'b1;
    #1;
    chk("abort valid", int'(bus.out_valid), 0);
    chk("abort index", int'(bus.out_index), 0);
    chk("abort count", int'(bus.out_count), 0);
    chk("abort busy",  int'(bus.out_busy),  0);
    chk("abort done",  int'(bus.out_done),  0);
    chk("abort total", int'(bus.out_total), 0);
    step();
    rst = 1'b0;
    chk("abort no done", int'(bus.out_done), 0);
    step();
    chk("abort no done 2", int'(bus.out_done), 0);
    chk("abort idle",      int'(bus.out_busy), 0);

    scan("restart", 25'h0000010, "0001000011000000000000000", -1, 0, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
